cnn_region_loader: RTL and testbench

Parametrised host-facing buffer bank for the CNN accelerator: N_REGIONS on-chip RAM regions (input image plus per-layer weights) are streamed from the host bus with auto-incrementing pointers, sealed, read back, then handed to a layer sequencer that pulses each layer engine in turn and waits for its done. Sits between the Avalon-style slave bus and the layer engines; layer engines read region contents through a dedicated read port.

---
 rtl/cnn_loader_pkg.sv | 28 ++
 rtl/cnn_region_loader_ram.sv | 37 +++
 rtl/cnn_region_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_cnn_region_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cnn_loader_pkg.sv
// Shared constants for the CNN region loader: bus register map, control and
// status bit positions, and the layer sequencer state encoding.
package cnn_loader_pkg;

  // Register offsets on address[3:0]; offsets below N_REGIONS are region data ports
  localparam logic [3:0] ADDR_CTRL   = 4'hC;
  localparam logic [3:0] ADDR_SEAL   = 4'hD;
  localparam logic [3:0] ADDR_STATUS = 4'hE;

  // CTRL write bits
  localparam int CTRL_REWIND = 0;
  localparam int CTRL_START  = 1;

  // STATUS read bits; loaded[3:0] occupies [ST_LOADED +: 4]
  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_SERR   = 3;
  localparam int ST_LOADED = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/cnn_region_loader_ram.sv
// One RAM region: a single write port plus two independent registered read
// ports (host bus side and layer engine side). Contents are never reset.
module region_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16384,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              hre_i,
  input  logic [AW-1:0]     haddr_i,
  output logic [DATA_W-1:0] hdata_o,
  input  logic              lre_i,
  input  logic [AW-1:0]     laddr_i,
  output logic [DATA_W-1:0] ldata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Host write port
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Host read port, one cycle latency
  always_ff @(posedge clk) begin
    if (hre_i) hdata_o <= mem[haddr_i];
  end

  // Layer read port, one cycle latency, independent of the host side
  always_ff @(posedge clk) begin
    if (lre_i) ldata_o <= mem[laddr_i];
  end

endmodule

// File: rtl/cnn_region_loader.sv
// Host-facing buffer bank: streams host words into N_REGIONS RAM regions with
// auto-incrementing pointers, seals and reads them back, and runs a layer
// sequencer that pulses each layer engine and waits for its done.
module cnn_region_loader
  import cnn_loader_pkg::*;
#(
  parameter int N_REGIONS = 5,
  parameter int DEPTH     = 16384,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 19,
  parameter int N_LAYERS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     chipselect,
  input  logic                     write,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  input  logic                     lyr_rd_en,
  input  logic [3:0]               lyr_rd_region,
  input  logic [$clog2(DEPTH)-1:0] lyr_rd_addr,
  output logic [DATA_W-1:0]        lyr_rd_data,
  output logic [N_LAYERS-1:0]      layer_start,
  input  logic [N_LAYERS-1:0]      layer_done,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int KW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  // Per-region pointer state; len is 0 until the region is sealed
  logic [N_REGIONS-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [N_REGIONS-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [N_REGIONS-1:0][PW-1:0] len_q, len_d;
  logic [N_REGIONS-1:0]         loaded_q, loaded_d;
  logic                         ovf_q, ovf_d;
  logic                         serr_q, serr_d;

  // Read-return steering: which source feeds readdata / lyr_rd_data next cycle
  logic [N_REGIONS-1:0] hsel_q, hsel_d;
  logic [N_REGIONS-1:0] lsel_q;
  logic [DATA_W-1:0]    stat_q, stat_d;

  seq_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;

  // Bus decode
  logic [3:0] a;
  logic       bus_wr, bus_rd, ctrl_wr, rewind, start_req, start_ok;
  logic [N_REGIONS-1:0] wr_hit, rd_hit, seal_hit, we, rd_ok, lre;
  logic [N_REGIONS-1:0][DATA_W-1:0] host_q, lyr_q;
  logic [11:0]       ld_pad;
  logic [DATA_W-1:0] status;

  assign a         = address[3:0];
  assign bus_wr    = chipselect & write;
  assign bus_rd    = chipselect & read;
  assign ctrl_wr   = bus_wr && (a == ADDR_CTRL);
  assign rewind    = ctrl_wr && writedata[CTRL_REWIND] &&
                     ((state_q == S_IDLE) || (state_q == S_DONE));
  assign start_req = ctrl_wr && writedata[CTRL_START];
  // A combined REWIND+START is rejected: the rewind drops every loaded flag
  assign start_ok  = start_req && (state_q == S_IDLE) && (&loaded_q) &&
                     !writedata[CTRL_REWIND];

  assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done = (state_q == S_DONE);

  // Per-region strobes; a write and read in the same cycle lets the write win
  always_comb begin
    wr_hit   = '0;
    rd_hit   = '0;
    seal_hit = '0;
    we       = '0;
    rd_ok    = '0;
    lre      = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      wr_hit[r]   = bus_wr && !busy && (a == 4'(r));
      rd_hit[r]   = bus_rd && !bus_wr && !busy && (a == 4'(r));
      seal_hit[r] = bus_wr && !busy && (a == ADDR_SEAL) && (writedata == DATA_W'(r));
      we[r]       = wr_hit[r] && !loaded_q[r] && (wr_ptr_q[r] < DEPTH_P);
      rd_ok[r]    = rd_hit[r] && (rd_ptr_q[r] < len_q[r]);
      lre[r]      = lyr_rd_en && (lyr_rd_region == 4'(r));
    end
  end

  // Pointer, seal and sticky-flag next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    hsel_d   = rd_ok;
    for (int r = 0; r < N_REGIONS; r++) begin
      if (rewind) begin
        wr_ptr_d[r] = '0;
        rd_ptr_d[r] = '0;
        len_d[r]    = '0;
        loaded_d[r] = 1'b0;
      end else begin
        if (we[r]) begin
          wr_ptr_d[r] = wr_ptr_q[r] + 1'b1;
          // Filling the last word seals the region at full length
          if (wr_ptr_q[r] == LAST_P) begin
            loaded_d[r] = 1'b1;
            len_d[r]    = DEPTH_P;
          end
        end
        if (wr_hit[r] && !we[r]) ovf_d = 1'b1;
        if (seal_hit[r]) begin
          loaded_d[r] = 1'b1;
          len_d[r]    = wr_ptr_q[r];
        end
        if (rd_ok[r]) rd_ptr_d[r] = rd_ptr_q[r] + 1'b1;
      end
    end
    if (rewind) ovf_d = 1'b0;
  end

  assign serr_d = serr_q | (start_req & ~start_ok);

  // STATUS byte; only the first four loaded flags fit
  assign ld_pad = 12'(loaded_q);
  assign status = DATA_W'({ld_pad[3:0], serr_q, ovf_q, done, busy});
  assign stat_d = (bus_rd && (a == ADDR_STATUS)) ? status : '0;

  // Loader state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      loaded_q <= '0;
      ovf_q    <= 1'b0;
      serr_q   <= 1'b0;
      hsel_q   <= '0;
      lsel_q   <= '0;
      stat_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      serr_q   <= serr_d;
      hsel_q   <= hsel_d;
      lsel_q   <= lre;
      stat_q   <= stat_d;
    end
  end

  // RAM regions
  for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
    region_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (we[g]),
      .waddr_i (wr_ptr_q[g][AW-1:0]),
      .wdata_i (writedata),
      .hre_i   (rd_ok[g]),
      .haddr_i (rd_ptr_q[g][AW-1:0]),
      .hdata_o (host_q[g]),
      .lre_i   (lre[g]),
      .laddr_i (lyr_rd_addr),
      .ldata_o (lyr_q[g])
    );
  end

  // Read-data return muxes; unselected sources contribute zero
  always_comb begin
    readdata    = stat_q;
    lyr_rd_data = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      if (hsel_q[r]) readdata    = readdata | host_q[r];
      if (lsel_q[r]) lyr_rd_data = lyr_rd_data | lyr_q[r];
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Sequencer next state: one start pulse per stage, then wait for that stage's done
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: if (start_ok) begin
        state_d = S_ISSUE;
        k_d     = '0;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (layer_done[k_q]) begin
        if (k_q == KW'(N_LAYERS - 1)) state_d = S_DONE;
        else begin
          state_d = S_ISSUE;
          k_d     = k_q + 1'b1;
        end
      end
      S_DONE: if (rewind) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign layer_start = (state_q == S_ISSUE) ? (N_LAYERS'(1) << k_q) : '0;

  logic unused_ok;
  assign unused_ok = ^address[ADDR_W-1:4];

endmodule

// File: tb/tb_cnn_region_loader.sv
// Directed bench for cnn_region_loader with DEPTH=4 so auto-seal is reachable.
module tb_cnn_region_loader;

  localparam int NR = 5, DEPTH = 4, DW = 8, AWB = 19, NL = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            chipselect, write, read;
  logic [AWB-1:0]  address;
  logic [DW-1:0]   writedata, readdata;
  logic            lyr_rd_en;
  logic [3:0]      lyr_rd_region;
  logic [1:0]      lyr_rd_addr;
  logic [DW-1:0]   lyr_rd_data;
  logic [NL-1:0]   layer_start, layer_done;
  logic            busy, done;

  int total = 0, bad = 0;

  cnn_region_loader #(.N_REGIONS(NR), .DEPTH(DEPTH), .DATA_W(DW),
                      .ADDR_W(AWB), .N_LAYERS(NL)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata), .readdata(readdata),
    .lyr_rd_en(lyr_rd_en), .lyr_rd_region(lyr_rd_region), .lyr_rd_addr(lyr_rd_addr),
    .lyr_rd_data(lyr_rd_data), .layer_start(layer_start), .layer_done(layer_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = AWB'(a); writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = AWB'(a);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic lyr_rd(input logic [3:0] r, input logic [1:0] ad, output logic [7:0] d);
    @(negedge clk);
    lyr_rd_en = 1'b1; lyr_rd_region = r; lyr_rd_addr = ad;
    @(negedge clk);
    lyr_rd_en = 1'b0;
    d = lyr_rd_data;
  endtask

  task automatic wait_start();
    int n = 0;
    while (layer_start == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  logic [7:0] d;
  logic [7:0] exp_r1 [4] = '{8'h11, 8'h22, 8'h33, 8'h00};

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; lyr_rd_en = 1'b0; lyr_rd_region = '0;
    lyr_rd_addr = '0; layer_done = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_readdata", readdata, 0);
    chk("rst_lyr_data", lyr_rd_data, 0);
    chk("rst_lstart", layer_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    bus_rd(4'hE, d); chk("rst_status", d, 8'h00);

    // Region 1: three words, seal, read back past the end
    bus_wr(4'd1, 8'h11); bus_wr(4'd1, 8'h22); bus_wr(4'd1, 8'h33);
    bus_wr(4'hD, 8'd1);
    for (int i = 0; i < 4; i++) begin
      bus_rd(4'd1, d); chk($sformatf("r1_rd%0d", i), d, exp_r1[i]);
    end
    bus_rd(4'hE, d); chk("status_r1", d, 8'h20);

    // Region 0: five writes into a 4-deep region
    for (int i = 0; i < 5; i++) bus_wr(4'd0, 8'hA0 + 8'(i));
    bus_rd(4'hE, d); chk("status_ovf", d, 8'h34);
    for (int i = 0; i < 4; i++) begin
      bus_rd(4'd0, d); chk($sformatf("r0_rd%0d", i), d, 8'hA0 + 8'(i));
    end
    bus_rd(4'd0, d); chk("r0_rd_end", d, 8'h00);

    // START with region 2 unsealed is rejected
    bus_wr(4'hC, 8'h02);
    chk("bad_start_busy", busy, 0);
    bus_rd(4'hE, d); chk("status_serr", d, 8'h3C);

    bus_wr(4'hD, 8'd2); bus_wr(4'hD, 8'd3); bus_wr(4'hD, 8'd4);
    bus_wr(4'hD, 8'd9);
    bus_rd(4'hE, d); chk("status_all", d, 8'hFC);

    lyr_rd(4'd1, 2'd2, d); chk("lyr_r1a2", d, 8'h33);
    lyr_rd(4'd0, 2'd3, d); chk("lyr_r0a3", d, 8'hA3);

    // Full sequencer run
    bus_wr(4'hC, 8'h02);
    chk("start_busy", busy, 1);
    for (int k = 0; k < NL; k++) begin
      wait_start();
      chk($sformatf("lstart%0d", k), layer_start, 32'(1 << k));
      @(negedge clk);
      chk($sformatf("lstart%0d_1cyc", k), layer_start, 0);
      if (k == 0) begin
        layer_done = 4'b0100;
        @(negedge clk);
        layer_done = '0;
        chk("spurious_ignored", layer_start, 0);
      end else if (k == 1) begin
        lyr_rd(4'd1, 2'd2, d); chk("lyr_busy", d, 8'h33);
      end else if (k == 2) begin
        bus_rd(4'hE, d); chk("status_busy", d, 8'hFD);
      end else begin
        @(negedge clk);
      end
      chk($sformatf("done_pre%0d", k), done, 0);
      layer_done = NL'(1 << k);
      @(negedge clk);
      layer_done = '0;
    end
    chk("done_set", done, 1);
    chk("done_busy", busy, 0);
    bus_rd(4'hE, d); chk("status_done", d, 8'hFE);

    bus_wr(4'hC, 8'h01);
    chk("rewind_done", done, 0);
    bus_rd(4'hE, d); chk("status_rewind", d, 8'h08);

    // Reset in the middle of stage 1
    for (int r = 0; r < NR; r++) bus_wr(4'hD, 8'(r));
    bus_wr(4'hC, 8'h02);
    wait_start();
    chk("r2_lstart0", layer_start, 1);
    @(negedge clk); @(negedge clk);
    layer_done = 4'b0001;
    @(negedge clk);
    layer_done = '0;
    chk("r2_lstart1", layer_start, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lstart", layer_start, 0);
    layer_done = 4'b0010;
    @(negedge clk);
    layer_done = '0;
    chk("late_done_lstart", layer_start, 0);
    chk("late_done_busy", busy, 0);
    bus_rd(4'hE, d); chk("mid_rst_status", d, 8'h00);
    lyr_rd(4'd1, 2'd2, d); chk("ram_kept", d, 8'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
